oled_spi_arbiter: RTL and testbench
===================================

OLED_SPI_ARBITER -- requirements
Module: oled_spi_arbiter

Interface
REQ-001 Parameter CLK_DIV, default 4: SCLK half-period in CLK cycles; legal range 1..255.
REQ-002 Parameter LOCK_TIMEOUT, default 255: idle cycles before a held lock is released; legal range 1..65535.
REQ-003 Parameter NREQ, fixed at 3: requester count; index 0 is init, 1 is operation, 2 is UART.
REQ-004 CLK  in  1  clock.
REQ-005 RST  in  1  reset, synchronous, active-high.
REQ-006 req_valid  in  3  per-requester byte-valid.
REQ-007 req_data  in  24  byte per requester; requester i uses bits [8i+7:8i].
REQ-008 req_dc  in  3  per-requester D/C flag: 0 is command, 1 is data.
REQ-009 req_last  in  3  byte closes the requester's transaction and releases the lock.
REQ-010 req_ready  out  3  one-cycle pulse marking acceptance of the presented byte.
REQ-011 grant  out  3  one-hot owner of the bus; 0 when the bus is unowned.
REQ-012 SDIN  out  1  SPI data, MSB first.
REQ-013 SCLK  out  1  SPI clock; idles high.
REQ-014 DC  out  1  D/C of the byte in flight.
REQ-015 busy  out  1  high while a byte is shifting.
REQ-016 byte_done  out  1  one-cycle pulse after the 8th SCLK rising edge.

Function
REQ-017 States SHALL be ARB, SHIFT and DONE.
REQ-018 ARB, unlocked: the lowest-index requester with valid SHALL win; fixed priority 0>1>2.
REQ-019 ARB, locked: only the lock owner SHALL be served; other requests SHALL wait unacknowledged.
REQ-020 Acceptance SHALL occur in an ARB cycle where the selected requester has valid=1.
  - That cycle: req_ready[i]=1 and grant[i]=1.
  - req_data, req_dc and req_last SHALL be latched in that cycle.
  - The lock SHALL be set to i.
  - Next state SHALL be SHIFT.
REQ-021 SHIFT SHALL transmit each bit, MSB first, in two phases:
  - SCLK low for CLK_DIV cycles, with SDIN updated on the first low cycle;
  - then SCLK high for CLK_DIV cycles.
  - The 8 bits SHALL take exactly 16*CLK_DIV cycles.
REQ-022 DC SHALL equal the latched flag for the whole of SHIFT and SHALL hold its value afterwards.
REQ-023 busy SHALL be 1 in SHIFT and 0 in every other state.
REQ-024 DONE SHALL last one cycle, during which byte_done=1.
  - If the latched last=1, the lock SHALL clear and grant SHALL become 0 on the next cycle.
  - Next state SHALL be ARB.
REQ-025 Back-to-back bytes SHALL have a minimum spacing of 16*CLK_DIV+2 cycles from acceptance to acceptance.
REQ-026 Lock timeout: the lock SHALL clear after LOCK_TIMEOUT consecutive ARB cycles with the owner's valid=0.
  - Timeout clears grant.
  - No pulse is generated on timeout.
REQ-027 A requester's valid dropping before acceptance SHALL cancel its request without side effects.
REQ-028 A change of req_data or req_dc during SHIFT SHALL NOT affect the byte in flight.
REQ-029 grant SHALL stay constant from acceptance through DONE.

Reset
REQ-030 RST=1 at a clock edge SHALL produce, on that edge, the following values:
  - state=ARB;
  - lock cleared, timeout counter cleared;
  - SCLK=1, SDIN=0, DC=0;
  - busy=0, byte_done=0, req_ready=0, grant=0.
REQ-031 Reset mid-SHIFT SHALL abort the byte with no byte_done and no further SCLK edges.
REQ-032 The first acceptance after reset SHALL be possible in the first cycle with RST=0.

Structure
REQ-033 Shared package oled_pkg SHALL hold:
  - the state encoding;
  - NREQ;
  - requester index constants REQ_INIT=0, REQ_OPER=1, REQ_UART=2.
REQ-034 Sub-module spi_byte_shift SHALL hold the divider, the bit counter and the shift register.
  - Its interface: load, data, sclk, sdo and done.
  - Arbitration and lock logic SHALL stay in oled_spi_arbiter.

Verification (CLK_DIV=2, LOCK_TIMEOUT=8)
REQ-035 Single byte:
  - Stimulus: req0 sends 0xA5 with dc=0, last=1.
  - Response: SDIN at 8 SCLK rising edges is 1,0,1,0,0,1,0,1; DC=0; byte_done 33 cycles after req_ready; grant returns to 000.
REQ-036 Simultaneous requests:
  - Stimulus: req0 sends 0x81 and req2 sends 0x3C in the same cycle.
  - Response: 0x81 transmitted first; req2 accepted in the ARB cycle following DONE.
REQ-037 Lock holding:
  - Stimulus: req1 sends 0x10, 0x20, 0x30 (last on 0x30), with req0 valid from the second byte.
  - Response: req0 is not acknowledged until after the byte_done of 0x30.
REQ-038 Lock timeout:
  - Stimulus: req1 sends 0x55 with last=0, then deasserts valid; req2 is valid.
  - Response: grant=010 for 8 ARB cycles, then req2 accepted.
REQ-039 Reset mid-byte:
  - Stimulus: RST pulse after the 3rd SCLK rising edge.
  - Response: next cycle SCLK=1, busy=0, grant=000; no byte_done; a new byte is accepted immediately after RST falls.
REQ-040 Minimum divider:
  - Stimulus: CLK_DIV=1, bytes 0xFF then 0x00 from req0, with data as dc=1.
  - Response: each byte takes 16 SHIFT cycles; acceptance spacing is 18 cycles; DC=1 throughout.

Source files
------------

// File: rtl/oled_pkg.sv
// Shared definitions for the OLED SPI arbiter: controller state encoding and
// requester indices.
package oled_pkg;

  localparam int NREQ = 3;

  localparam logic [1:0] REQ_INIT = 2'd0;
  localparam logic [1:0] REQ_OPER = 2'd1;
  localparam logic [1:0] REQ_UART = 2'd2;

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic [NREQ-1:0] idx_onehot(input logic [1:0] idx);
    case (idx)
      2'd0:    idx_onehot = 3'b001;
      2'd1:    idx_onehot = 3'b010;
      2'd2:    idx_onehot = 3'b100;
      default: idx_onehot = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/spi_byte_shift.sv
// Serialises one byte MSB first: each bit spends CLK_DIV cycles with SCLK low
// and CLK_DIV cycles with SCLK high; SCLK idles high.
module spi_byte_shift #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data,
  output logic       sclk,
  output logic       sdo,
  output logic       done
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic       active_q, active_d;
  logic       sclk_q, sclk_d;
  logic       sdo_q, sdo_d;
  logic [6:0] sh_q, sh_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] div_q, div_d;
  logic       phase_end;

  // Divider, phase toggling and bit shifting
  always_comb begin
    active_d  = active_q;
    sclk_d    = sclk_q;
    sdo_d     = sdo_q;
    sh_d      = sh_q;
    bit_d     = bit_q;
    div_d     = div_q;
    phase_end = active_q && (div_q == DIV_LAST);
    done      = phase_end && sclk_q && (bit_q == 3'd7);
    if (load) begin
      active_d = 1'b1;
      sclk_d   = 1'b0;
      sdo_d    = data[7];
      sh_d     = data[6:0];
      bit_d    = 3'd0;
      div_d    = 8'd0;
    end else if (phase_end) begin
      div_d = 8'd0;
      if (!sclk_q) begin
        sclk_d = 1'b1;
      end else if (bit_q == 3'd7) begin
        // Last high phase ends: stop with SCLK left at its idle level.
        active_d = 1'b0;
      end else begin
        sclk_d = 1'b0;
        sdo_d  = sh_q[6];
        sh_d   = {sh_q[5:0], 1'b0};
        bit_d  = bit_q + 3'd1;
      end
    end else if (active_q) begin
      div_d = div_q + 8'd1;
    end else begin
      div_d = 8'd0;
    end
  end

  // Shifter state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      sclk_q   <= 1'b1;
      sdo_q    <= 1'b0;
      sh_q     <= 7'd0;
      bit_q    <= 3'd0;
      div_q    <= 8'd0;
    end else begin
      active_q <= active_d;
      sclk_q   <= sclk_d;
      sdo_q    <= sdo_d;
      sh_q     <= sh_d;
      bit_q    <= bit_d;
      div_q    <= div_d;
    end
  end

  assign sclk = sclk_q;
  assign sdo  = sdo_q;

endmodule

// File: rtl/oled_spi_arbiter.sv
// Arbitrates three byte producers onto one OLED SPI link, with a per-transaction
// bus lock that is released by req_last or by an idle timeout.
module oled_spi_arbiter
  import oled_pkg::*;
#(
  parameter int CLK_DIV      = 4,
  parameter int LOCK_TIMEOUT = 255
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NREQ-1:0] req_valid,
  input  logic [23:0]     req_data,
  input  logic [NREQ-1:0] req_dc,
  input  logic [NREQ-1:0] req_last,
  output logic [NREQ-1:0] req_ready,
  output logic [NREQ-1:0] grant,
  output logic            SDIN,
  output logic            SCLK,
  output logic            DC,
  output logic            busy,
  output logic            byte_done
);

  localparam logic [15:0] TO_LAST = 16'(LOCK_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        lock_q, lock_d;
  logic [1:0]  owner_q, owner_d;
  logic        dc_q, dc_d;
  logic        last_q, last_d;
  logic [15:0] to_cnt_q, to_cnt_d;

  logic [1:0]  sel_idx;
  logic        sel_valid;
  logic        sel_dc;
  logic        sel_last;
  logic [7:0]  sel_data;
  logic        accept;
  logic        shift_done;

  // Requester selection: the lock owner if locked, otherwise fixed priority
  always_comb begin
    sel_idx = REQ_UART;
    if (lock_q) begin
      sel_idx = owner_q;
    end else if (req_valid[0]) begin
      sel_idx = REQ_INIT;
    end else if (req_valid[1]) begin
      sel_idx = REQ_OPER;
    end else begin
      sel_idx = REQ_UART;
    end
    case (sel_idx)
      2'd0: begin
        sel_valid = req_valid[0];
        sel_data  = req_data[7:0];
        sel_dc    = req_dc[0];
        sel_last  = req_last[0];
      end
      2'd1: begin
        sel_valid = req_valid[1];
        sel_data  = req_data[15:8];
        sel_dc    = req_dc[1];
        sel_last  = req_last[1];
      end
      2'd2: begin
        sel_valid = req_valid[2];
        sel_data  = req_data[23:16];
        sel_dc    = req_dc[2];
        sel_last  = req_last[2];
      end
      default: begin
        sel_valid = 1'b0;
        sel_data  = 8'd0;
        sel_dc    = 1'b0;
        sel_last  = 1'b0;
      end
    endcase
    accept = (state_q == ST_ARB) && sel_valid && !RST;
  end

  // Next-state, lock and timeout logic
  always_comb begin
    state_d  = state_q;
    lock_d   = lock_q;
    owner_d  = owner_q;
    dc_d     = dc_q;
    last_d   = last_q;
    to_cnt_d = to_cnt_q;
    case (state_q)
      ST_ARB: begin
        if (accept) begin
          state_d  = ST_SHIFT;
          lock_d   = 1'b1;
          owner_d  = sel_idx;
          dc_d     = sel_dc;
          last_d   = sel_last;
          to_cnt_d = 16'd0;
        end else if (lock_q) begin
          // Locked and the owner is idle: count towards releasing the bus.
          if (to_cnt_q == TO_LAST) begin
            lock_d   = 1'b0;
            to_cnt_d = 16'd0;
          end else begin
            to_cnt_d = to_cnt_q + 16'd1;
          end
        end else begin
          to_cnt_d = 16'd0;
        end
      end
      ST_SHIFT: begin
        if (shift_done) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_d  = ST_ARB;
        to_cnt_d = 16'd0;
        if (last_q) begin
          lock_d = 1'b0;
        end else begin
          lock_d = lock_q;
        end
      end
      default: begin
        state_d  = ST_ARB;
        lock_d   = 1'b0;
        to_cnt_d = 16'd0;
      end
    endcase
  end

  // Handshake and ownership outputs
  always_comb begin
    req_ready = 3'b000;
    grant     = 3'b000;
    if (accept) begin
      req_ready = idx_onehot(sel_idx);
    end else begin
      req_ready = 3'b000;
    end
    if (RST) begin
      grant = 3'b000;
    end else if (lock_q) begin
      grant = idx_onehot(owner_q);
    end else if (accept) begin
      grant = idx_onehot(sel_idx);
    end else begin
      grant = 3'b000;
    end
  end

  // Controller registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_ARB;
      lock_q   <= 1'b0;
      owner_q  <= 2'd0;
      dc_q     <= 1'b0;
      last_q   <= 1'b0;
      to_cnt_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      lock_q   <= lock_d;
      owner_q  <= owner_d;
      dc_q     <= dc_d;
      last_q   <= last_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  assign DC        = dc_q;
  assign busy      = (state_q == ST_SHIFT);
  assign byte_done = (state_q == ST_DONE);

  spi_byte_shift #(
    .CLK_DIV(CLK_DIV)
  ) u_shift (
    .clk (CLK),
    .rst (RST),
    .load(accept),
    .data(sel_data),
    .sclk(SCLK),
    .sdo (SDIN),
    .done(shift_done)
  );

endmodule

// File: tb/tb_oled_spi_arbiter.sv
// Directed bench for oled_spi_arbiter: a table of single-byte transfers plus
// hand-written sequences for priority, locking, timeout, reset and CLK_DIV=1.
module tb_oled_spi_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic [2:0]  req_valid, req_dc, req_last, req_ready, grant;
  logic [23:0] req_data;
  logic        SDIN, SCLK, DC, busy, byte_done;

  logic [2:0]  r2_valid, r2_dc, r2_last, r2_ready, r2_grant;
  logic [23:0] r2_data;
  logic        r2_SDIN, r2_SCLK, r2_DC, r2_busy, r2_byte_done;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  oled_spi_arbiter #(.CLK_DIV(2), .LOCK_TIMEOUT(8)) dut (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_data(req_data),
    .req_dc(req_dc), .req_last(req_last), .req_ready(req_ready), .grant(grant),
    .SDIN(SDIN), .SCLK(SCLK), .DC(DC), .busy(busy), .byte_done(byte_done)
  );

  oled_spi_arbiter #(.CLK_DIV(1), .LOCK_TIMEOUT(8)) dut_div1 (
    .CLK(CLK), .RST(RST), .req_valid(r2_valid), .req_data(r2_data),
    .req_dc(r2_dc), .req_last(r2_last), .req_ready(r2_ready), .grant(r2_grant),
    .SDIN(r2_SDIN), .SCLK(r2_SCLK), .DC(r2_DC), .busy(r2_busy), .byte_done(r2_byte_done)
  );

  typedef struct {
    int         idx;
    logic [7:0] data;
    logic       dc;
    logic [7:0] exp_bits;
    logic [2:0] exp_onehot;
  } vec_t;

  vec_t tbl [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Present one byte on requester idx, check the handshake, drop valid after the accept edge.
  task automatic send(input int idx, input logic [7:0] data, input logic dc, input logic last,
                      input logic [2:0] exp_onehot);
    @(negedge CLK);
    req_valid[idx] = 1'b1;
    req_data[idx*8 +: 8] = data;
    req_dc[idx] = dc;
    req_last[idx] = last;
    #1;
    chk("accept_grant_ready", {grant, req_ready}, {exp_onehot, exp_onehot});
    @(posedge CLK);
    #1;
    req_valid[idx] = 1'b0;
  endtask

  // Follow a byte from the cycle after acceptance until byte_done.
  task automatic run_byte(input logic exp_dc, output logic [7:0] bits, output int lat,
                          output int nbusy, output int dc_bad, output logic [2:0] rdy_or);
    logic prev;
    prev = 1'b1;
    bits = 8'd0; lat = -1; nbusy = 0; dc_bad = 0; rdy_or = 3'b000;
    for (int n = 1; n <= 200; n++) begin
      @(negedge CLK);
      if (SCLK && !prev) bits = {bits[6:0], SDIN};
      prev = SCLK;
      if (busy) begin
        nbusy++;
        if (DC !== exp_dc) dc_bad++;
      end
      rdy_or = rdy_or | req_ready;
      if (byte_done) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bits;
    int lat, nbusy, dc_bad, rises, spacing;
    logic [2:0] rdy_or;
    logic prev;

    tbl[0] = '{0, 8'hA5, 1'b0, 8'hA5, 3'b001};
    tbl[1] = '{1, 8'h3C, 1'b1, 8'h3C, 3'b010};
    tbl[2] = '{2, 8'h81, 1'b1, 8'h81, 3'b100};
    tbl[3] = '{0, 8'h0F, 1'b1, 8'h0F, 3'b001};

    RST = 1'b1;
    req_valid = 3'b000; req_dc = 3'b000; req_last = 3'b000; req_data = 24'd0;
    r2_valid = 3'b000; r2_dc = 3'b000; r2_last = 3'b000; r2_data = 24'd0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("reset_outputs", {SCLK, SDIN, DC, busy, byte_done, req_ready, grant}, 11'b100_0000_0000);
    chk("reset_div1_outputs", {r2_SCLK, r2_busy, r2_grant}, 5'b1_0_000);
    RST = 1'b0;

    // Table of single bytes, each closing its transaction
    for (int i = 0; i < 4; i++) begin
      send(tbl[i].idx, tbl[i].data, tbl[i].dc, 1'b1, tbl[i].exp_onehot);
      run_byte(tbl[i].dc, bits, lat, nbusy, dc_bad, rdy_or);
      chk("tbl_bits", bits, tbl[i].exp_bits);
      chk("tbl_done_latency", lat, 33);
      chk("tbl_busy_cycles", nbusy, 32);
      chk("tbl_dc_during", dc_bad, 0);
      @(negedge CLK);
      chk("tbl_after", {grant, busy, SCLK, DC}, {3'b000, 1'b0, 1'b1, tbl[i].dc});
    end

    // Simultaneous requests from 0 and 2
    @(negedge CLK);
    req_valid = 3'b101; req_data = {8'h3C, 8'h00, 8'h81};
    req_dc = 3'b100; req_last = 3'b101;
    #1;
    chk("simul_first", {grant, req_ready}, 6'b001_001);
    @(posedge CLK); #1;
    req_valid[0] = 1'b0;
    run_byte(1'b0, bits, lat, nbusy, dc_bad, rdy_or);
    chk("simul_bits_81", bits, 8'h81);
    chk("simul_req2_waits", rdy_or[2], 1'b0);
    @(negedge CLK); #1;
    chk("simul_second", {grant, req_ready}, 6'b100_100);
    @(posedge CLK); #1;
    req_valid[2] = 1'b0;
    run_byte(1'b1, bits, lat, nbusy, dc_bad, rdy_or);
    chk("simul_bits_3c", bits, 8'h3C);
    @(negedge CLK);

    // Lock holding: req1 sends three bytes, req0 waits
    send(1, 8'h10, 1'b0, 1'b0, 3'b010);
    run_byte(1'b0, bits, lat, nbusy, dc_bad, rdy_or);
    req_valid[0] = 1'b1; req_data[7:0] = 8'h99; req_dc[0] = 1'b0; req_last[0] = 1'b1;
    send(1, 8'h20, 1'b0, 1'b0, 3'b010);
    run_byte(1'b0, bits, lat, nbusy, dc_bad, rdy_or);
    chk("lock_req0_wait_b2", rdy_or[0], 1'b0);
    send(1, 8'h30, 1'b0, 1'b1, 3'b010);
    run_byte(1'b0, bits, lat, nbusy, dc_bad, rdy_or);
    chk("lock_req0_wait_b3", rdy_or[0], 1'b0);
    chk("lock_bits_30", bits, 8'h30);
    @(negedge CLK); #1;
    chk("lock_release_req0", {grant, req_ready}, 6'b001_001);
    @(posedge CLK); #1;
    req_valid[0] = 1'b0;
    run_byte(1'b0, bits, lat, nbusy, dc_bad, rdy_or);
    chk("lock_bits_99", bits, 8'h99);
    @(negedge CLK);

    // Lock timeout: owner goes idle without last, req2 waits 8 ARB cycles
    send(1, 8'h55, 1'b0, 1'b0, 3'b010);
    run_byte(1'b0, bits, lat, nbusy, dc_bad, rdy_or);
    chk("timeout_bits_55", bits, 8'h55);
    req_valid[2] = 1'b1; req_data[23:16] = 8'hC6; req_dc[2] = 1'b0; req_last[2] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK); #1;
      chk("timeout_held", {grant, req_ready}, 6'b010_000);
    end
    @(negedge CLK); #1;
    chk("timeout_req2_accept", {grant, req_ready}, 6'b100_100);
    @(posedge CLK); #1;
    req_valid[2] = 1'b0;
    run_byte(1'b0, bits, lat, nbusy, dc_bad, rdy_or);
    chk("timeout_bits_c6", bits, 8'hC6);
    @(negedge CLK);

    // Reset after the 3rd SCLK rising edge
    send(0, 8'hC3, 1'b0, 1'b1, 3'b001);
    rises = 0; prev = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge CLK);
      if (SCLK && !prev) rises++;
      prev = SCLK;
      if (rises == 3) break;
    end
    chk("rst_mid_rises", rises, 3);
    RST = 1'b1;
    @(negedge CLK);
    chk("rst_mid_state", {SCLK, busy, grant, byte_done}, 6'b1_0_000_0);
    RST = 1'b0;
    req_valid[0] = 1'b1; req_data[7:0] = 8'h5A; req_dc[0] = 1'b1; req_last[0] = 1'b1;
    #1;
    chk("rst_mid_accept", {grant, req_ready}, 6'b001_001);
    @(posedge CLK); #1;
    req_valid[0] = 1'b0;
    run_byte(1'b1, bits, lat, nbusy, dc_bad, rdy_or);
    chk("rst_mid_bits_5a", bits, 8'h5A);
    chk("rst_mid_latency", lat, 33);
    chk("rst_mid_dc", dc_bad, 0);

    // CLK_DIV=1: back-to-back data bytes 0xFF then 0x00
    @(negedge CLK);
    r2_valid = 3'b001; r2_data[7:0] = 8'hFF; r2_dc = 3'b001; r2_last = 3'b000;
    #1;
    chk("div1_accept1", r2_ready, 3'b001);
    @(posedge CLK); #1;
    r2_data[7:0] = 8'h00; r2_last = 3'b001;
    spacing = -1; nbusy = 0; dc_bad = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge CLK);
      if (r2_busy) begin
        nbusy++;
        if (r2_DC !== 1'b1) dc_bad++;
      end
      if (r2_ready[0]) begin
        spacing = n;
        break;
      end
    end
    chk("div1_spacing", spacing, 18);
    chk("div1_busy1", nbusy, 16);
    @(posedge CLK); #1;
    r2_valid = 3'b000;
    lat = -1; nbusy = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge CLK);
      if (r2_busy) begin
        nbusy++;
        if (r2_DC !== 1'b1) dc_bad++;
      end
      if (r2_byte_done) begin
        lat = n;
        break;
      end
    end
    chk("div1_busy2", nbusy, 16);
    chk("div1_latency", lat, 17);
    chk("div1_dc", dc_bad, 0);
    @(negedge CLK);
    chk("div1_after", {r2_DC, r2_grant, r2_SCLK}, 5'b1_000_1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
